cg_iteration_ctrl: RTL

//  Downstream sequencer for the conjugate-gradient ALU. Consumes the ALU's stage-done strobes (vXv1_finish, mul_add3_finish, finish_all,

---
 rtl/cg_pkg.sv | 24 ++
 rtl/cg_iteration_ctrl_if.sv | 44 ++++
 rtl/cg_sat_counter.sv | 37 +++
 rtl/cg_iteration_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cg_pkg.sv
// Shared types and defaults for the conjugate-gradient iteration sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cg_pkg;

    localparam int CG_ITER_W = 16;
    localparam int CG_CYC_W  = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        PREP  = 3'd2,
        VXV1  = 3'd3,
        MXV   = 3'd4,
        GAP   = 3'd5,
        DONE  = 3'd6
    } cg_state_e;

    // States in which a CG iteration is actually running on the ALU.
    function automatic logic in_iteration(input cg_state_e s);
        return (s == VXV1) || (s == MXV);
    endfunction

endpackage

// File: rtl/cg_iteration_ctrl_if.sv
// Host + ALU signal bundle for the CG iteration sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start_req is a pulse, ALU strobes are level/pulse.
// Ports: master = sequencer side (drives ALU resets and host status),
//        slave  = environment side (host start/config, ALU done strobes).
interface cg_iteration_ctrl_if #(
    parameter int ITER_W = cg_pkg::CG_ITER_W,
    parameter int CYC_W  = cg_pkg::CG_CYC_W
);
    logic              start_req;
    logic [ITER_W-1:0] max_iter;
    logic [CYC_W-1:0]  watchdog_limit;
    logic              alu_pre_preprocess;
    logic              alu_vXv1_finish;
    logic              alu_mul_add3_finish;
    logic              alu_finish_all;
    logic              alu_reset;
    logic              reset_vXv1;
    logic              reset_mXv1;
    logic              busy;
    logic              done;
    logic              converged;
    logic              hit_max;
    logic              timed_out;
    logic [ITER_W-1:0] iter_count;
    logic [CYC_W-1:0]  last_iter_cycles;
    logic [CYC_W-1:0]  max_iter_cycles;

    modport master (
        input  start_req, max_iter, watchdog_limit,
        input  alu_pre_preprocess, alu_vXv1_finish, alu_mul_add3_finish, alu_finish_all,
        output alu_reset, reset_vXv1, reset_mXv1,
        output busy, done, converged, hit_max, timed_out,
        output iter_count, last_iter_cycles, max_iter_cycles
    );

    modport slave (
        output start_req, max_iter, watchdog_limit,
        output alu_pre_preprocess, alu_vXv1_finish, alu_mul_add3_finish, alu_finish_all,
        input  alu_reset, reset_vXv1, reset_mXv1,
        input  busy, done, converged, hit_max, timed_out,
        input  iter_count, last_iter_cycles, max_iter_cycles
    );
endinterface

// File: rtl/cg_sat_counter.sv
// Saturating up-counter with synchronous clear and equality compare.
// Latency: count visible 1 cycle after clr/en; eq is combinational on the count.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clr (priority over en), en, cmp_val -> cnt, eq (cnt == cmp_val).
module cg_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] cmp_val,
    output logic [W-1:0] cnt,
    output logic         eq
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign eq  = (cnt_q == cmp_val);
endmodule

// File: rtl/cg_iteration_ctrl.sv
// Sequences the CG ALU through iterations via its stage resets; caps, watchdogs, reports.
// Latency: all outputs registered; ALU resets/status change the cycle the FSM enters a state.
// Backpressure: start_req ignored while busy; ALU strobes ignored outside VXV1/MXV/GAP.
// Ports: clk, reset (async active-low), io (cg_iteration_ctrl_if.master).
// Optional: CG_ITER_STATS_EN builds last/max per-iteration cycle stats; otherwise they read 0.
module cg_iteration_ctrl
    import cg_pkg::*;
#(
    parameter int ITER_W     = CG_ITER_W,
    parameter int CYC_W      = CG_CYC_W,
    parameter int RST_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    cg_iteration_ctrl_if.master io
);
    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    cg_state_e         state_q, state_d;
    logic [ITER_W-1:0] iter_count_q, iter_count_d;
    logic [ITER_W-1:0] max_iter_q, max_iter_d;
    logic [CYC_W-1:0]  wd_limit_q, wd_limit_d;
    logic              alu_reset_q, alu_reset_d;
    logic              reset_vxv1_q, reset_vxv1_d;
    logic              reset_mxv1_q, reset_mxv1_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              converged_q, converged_d;
    logic              hit_max_q, hit_max_d;
    logic              timed_out_q, timed_out_d;

    logic              start_ok;
    logic              iter_end;
    logic              ma_ok;
    logic              wd_fire;
    logic [ITER_W-1:0] iter_next;

    logic [CYC_W-1:0]  cyc_cnt;
    logic              cyc_eq;
    logic              cyc_clr, cyc_en;
    logic [HOLD_W-1:0] hold_cnt_unused;
    logic              hold_eq;

    assign start_ok  = io.start_req && ((state_q == IDLE) || (state_q == DONE));
    assign ma_ok     = (state_q == MXV) && io.alu_mul_add3_finish;
    assign iter_next = (iter_count_q == '1) ? iter_count_q : iter_count_q + ITER_W'(1);

    // Per-iteration cycle counter: zero in the first VXV1 cycle, counts through MXV.
    assign cyc_clr = (state_d == VXV1) && (state_q != VXV1);
    assign cyc_en  = in_iteration(state_q);
    // Compare against limit-1 so DONE lands exactly 'limit' cycles after VXV1 entry.
    assign wd_fire = (wd_limit_q != '0) && cyc_eq && cyc_en;

    cg_sat_counter #(.W(CYC_W)) u_cyc_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (cyc_clr),
        .en      (cyc_en),
        .cmp_val (wd_limit_q - CYC_W'(1)),
        .cnt     (cyc_cnt),
        .eq      (cyc_eq)
    );

    // Holds the FSM in CLEAR for RST_CYCLES cycles; cleared whenever outside CLEAR.
    cg_sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (state_q != CLEAR),
        .en      (state_q == CLEAR),
        .cmp_val (HOLD_W'(RST_CYCLES - 1)),
        .cnt     (hold_cnt_unused),
        .eq      (hold_eq)
    );

    always_comb begin
        state_d      = state_q;
        iter_count_d = iter_count_q;
        max_iter_d   = max_iter_q;
        wd_limit_d   = wd_limit_q;
        converged_d  = converged_q;
        hit_max_d    = hit_max_q;
        timed_out_d  = timed_out_q;
        iter_end     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d      = CLEAR;
                    iter_count_d = '0;
                    converged_d  = 1'b0;
                    hit_max_d    = 1'b0;
                    timed_out_d  = 1'b0;
                    max_iter_d   = io.max_iter;
                    wd_limit_d   = io.watchdog_limit;
                end
            end
            CLEAR: begin
                if (hold_eq) state_d = PREP;
            end
            PREP: begin
                if (!io.alu_pre_preprocess) state_d = VXV1;
            end
            VXV1, MXV, GAP: begin
                if (io.alu_finish_all) begin
                    // Convergence wins, but a coincident iteration end still counts.
                    state_d     = DONE;
                    converged_d = 1'b1;
                    iter_end    = ma_ok;
                end else if (wd_fire) begin
                    state_d     = DONE;
                    timed_out_d = 1'b1;
                end else if (ma_ok) begin
                    iter_end = 1'b1;
                    if ((max_iter_q != '0) && (iter_next == max_iter_q)) begin
                        state_d   = DONE;
                        hit_max_d = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end else if ((state_q == VXV1) && io.alu_vXv1_finish) begin
                    state_d = MXV;
                end else if (state_q == GAP) begin
                    state_d = VXV1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (iter_end) iter_count_d = iter_next;

        // Outputs decode the next state so they change together with the state register.
        alu_reset_d  = (state_d == IDLE) || (state_d == CLEAR) || (state_d == DONE);
        reset_vxv1_d = !in_iteration(state_d);
        reset_mxv1_d = (state_d != MXV);
        busy_d       = (state_d != IDLE) && (state_d != DONE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            iter_count_q <= '0;
            max_iter_q   <= '0;
            wd_limit_q   <= '0;
            alu_reset_q  <= 1'b1;
            reset_vxv1_q <= 1'b1;
            reset_mxv1_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            converged_q  <= 1'b0;
            hit_max_q    <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_count_q <= iter_count_d;
            max_iter_q   <= max_iter_d;
            wd_limit_q   <= wd_limit_d;
            alu_reset_q  <= alu_reset_d;
            reset_vxv1_q <= reset_vxv1_d;
            reset_mxv1_q <= reset_mxv1_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            converged_q  <= converged_d;
            hit_max_q    <= hit_max_d;
            timed_out_q  <= timed_out_d;
        end
    end

    assign io.alu_reset  = alu_reset_q;
    assign io.reset_vXv1 = reset_vxv1_q;
    assign io.reset_mXv1 = reset_mxv1_q;
    assign io.busy       = busy_q;
    assign io.done       = done_q;
    assign io.converged  = converged_q;
    assign io.hit_max    = hit_max_q;
    assign io.timed_out  = timed_out_q;
    assign io.iter_count = iter_count_q;

`ifdef CG_ITER_STATS_EN
    logic [CYC_W-1:0] last_cyc_q, last_cyc_d;
    logic [CYC_W-1:0] max_cyc_q, max_cyc_d;
    logic [CYC_W-1:0] iter_len;

    // The iteration includes the cycle carrying mul_add3_finish, hence +1 (saturating).
    assign iter_len = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + CYC_W'(1);

    always_comb begin
        last_cyc_d = last_cyc_q;
        max_cyc_d  = max_cyc_q;
        if (start_ok) begin
            last_cyc_d = '0;
            max_cyc_d  = '0;
        end else if (iter_end) begin
            last_cyc_d = iter_len;
            if (iter_len > max_cyc_q) max_cyc_d = iter_len;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_cyc_q <= '0;
            max_cyc_q  <= '0;
        end else begin
            last_cyc_q <= last_cyc_d;
            max_cyc_q  <= max_cyc_d;
        end
    end

    assign io.last_iter_cycles = last_cyc_q;
    assign io.max_iter_cycles  = max_cyc_q;
`else
    logic unused_cyc_cnt;
    assign unused_cyc_cnt      = ^cyc_cnt;
    assign io.last_iter_cycles = '0;
    assign io.max_iter_cycles  = '0;
`endif

endmodule
